alu_apb_slave: RTL

ALU_APB_SLAVE -- requirements
Module: alu_apb_slave

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_core.sv | 93 +++++++++
 rtl/alu_apb_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the APB-attached ALU.
// Opcodes, register offsets, STATUS bit positions, default latency.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_st_e;

    typedef enum logic {
        CORE_IDLE,
        CORE_BUSY
    } core_st_e;

    localparam logic [7:0] OFF_OPA    = 8'h00;
    localparam logic [7:0] OFF_OPB    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_DIVZ    = 3;
    localparam int CTRL_START = 31;

    localparam int DEF_OP_LAT = 4;

endpackage

// File: rtl/alu_core.sv
// Multi-cycle ALU: latches operands on start, counts OP_LAT cycles,
// presents result/ovf together with a one-cycle done strobe.
module alu_core
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int OP_LAT = DEF_OP_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  alu_op_e      op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf
);

    localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

    core_st_e       st;
    logic [CW-1:0]  cnt;
    alu_op_e        op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= CORE_IDLE;
            cnt  <= '0;
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            unique case (st)
                CORE_IDLE: begin
                    if (start) begin
                        st   <= CORE_BUSY;
                        cnt  <= CW'(OP_LAT - 1);
                        op_q <= op;
                        a_q  <= opa;
                        b_q  <= opb;
                    end
                end
                CORE_BUSY: begin
                    if (cnt == '0) st <= CORE_IDLE;
                    else           cnt <= cnt - CW'(1);
                end
                default: st <= CORE_IDLE;
            endcase
        end
    end

    assign busy = (st == CORE_BUSY);
    assign done = busy && (cnt == '0);

    // Result is held stable by the latched operands; consumer samples on done.
    always_comb begin
        sum    = a_q + b_q;
        diff   = a_q - b_q;
        prod   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
        result = '0;
        ovf    = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                result = sum;
                ovf    = (a_q[W-1] == b_q[W-1])
                      && (sum[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a_q[W-1] != b_q[W-1])
                      && (diff[W-1] != a_q[W-1]);
            end
            OP_AND: result = a_q & b_q;
            OP_OR:  result = a_q | b_q;
            OP_XOR: result = a_q ^ b_q;
            OP_SHL: result = a_q << b_q[4:0];
            OP_SHR: result = a_q >> b_q[4:0];
            OP_MUL: begin
                result = prod[W-1:0];
                ovf    = |prod[2*W-1:W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_apb_slave.sv
// APB slave wrapping alu_core: register file, decode, error
// responses and wait states for RESULT reads while the ALU is busy.
module alu_apb_slave
    import alu_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int APB_BUS_SIZE = 32,
    parameter int OP_LAT       = DEF_OP_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_W:0]         paddr,
    input  logic [APB_BUS_SIZE-1:0] pwdata,
    output logic [APB_BUS_SIZE-1:0] prdata,
    output logic                    ready,
    output logic                    slv_err
);

    localparam int W  = APB_BUS_SIZE;
    localparam int AW = ADDR_W + 1;

    apb_st_e      apb_st;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic [W-1:0] result_q;
    alu_op_e      op_q;
    logic         done_q;
    logic         ovf_q;

    logic         core_busy;
    logic         core_done;
    logic         core_ovf;
    logic [W-1:0] core_res;

    logic a_opa, a_opb, a_ctrl, a_res, a_stat;
    logic busy_n, err, stall;
    logic setup_ph, wait_ph, wr_en, start;
    logic [W-1:0] rdata;
    logic [W-1:0] status;

    assign a_opa  = (paddr == AW'(OFF_OPA));
    assign a_opb  = (paddr == AW'(OFF_OPB));
    assign a_ctrl = (paddr == AW'(OFF_CTRL));
    assign a_res  = (paddr == AW'(OFF_RESULT));
    assign a_stat = (paddr == AW'(OFF_STATUS));

    // Values as they will stand in the cycle after this edge.
    always_comb begin
        busy_n = core_busy && !core_done;
        err = (paddr[1:0] != 2'b00)
           || !(a_opa || a_opb || a_ctrl || a_res || a_stat)
           || (pwrite && (a_res || a_stat))
           || (pwrite && busy_n && (a_opa || a_opb || a_ctrl));
        stall = !pwrite && a_res && busy_n;

        status          = '0;
        status[ST_BUSY] = busy_n;
        status[ST_DONE] = done_q || core_done;
        status[ST_OVF]  = core_done ? core_ovf : ovf_q;
        status[ST_DIVZ] = 1'b0;

        rdata = '0;
        unique case (1'b1)
            a_opa:   rdata = opa_q;
            a_opb:   rdata = opb_q;
            a_ctrl:  rdata = W'(op_q);
            a_res:   rdata = core_done ? core_res : result_q;
            a_stat:  rdata = status;
            default: ;
        endcase
    end

    assign setup_ph = psel && !penable;
    assign wait_ph  = psel && penable && !ready
                   && (apb_st != APB_IDLE);
    assign wr_en    = ready && psel && penable
                   && pwrite && !slv_err;
    assign start    = wr_en && a_ctrl && pwdata[CTRL_START];

    // apb_st is the phase sampled at the last edge; the response for
    // the following access cycle is registered at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apb_st  <= APB_IDLE;
            ready   <= 1'b0;
            slv_err <= 1'b0;
            prdata  <= '0;
        end else begin
            ready   <= 1'b0;
            slv_err <= 1'b0;
            prdata  <= '0;
            unique case (1'b1)
                setup_ph, wait_ph: begin
                    apb_st <= setup_ph ? APB_SETUP : APB_ACCESS;
                    if (!stall) begin
                        ready   <= 1'b1;
                        slv_err <= err;
                        prdata  <= (pwrite || err) ? '0 : rdata;
                    end
                end
                default: apb_st <= APB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            op_q     <= OP_ADD;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (core_done) begin
                result_q <= core_res;
                ovf_q    <= core_ovf;
                done_q   <= 1'b1;
            end
            if (wr_en) begin
                unique case (1'b1)
                    a_opa: opa_q <= pwdata;
                    a_opb: opb_q <= pwdata;
                    a_ctrl: begin
                        op_q <= alu_op_e'(pwdata[2:0]);
                        if (pwdata[CTRL_START]) begin
                            done_q <= 1'b0;
                            ovf_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    alu_core #(
        .W      (W),
        .OP_LAT (OP_LAT)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (alu_op_e'(pwdata[2:0])),
        .opa    (opa_q),
        .opb    (opb_q),
        .busy   (core_busy),
        .done   (core_done),
        .result (core_res),
        .ovf    (core_ovf)
    );

endmodule
